// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//
// Runs a job of ROUNDS back-to-back count runs on an attached counter. Each
// run issues a one-cycle count_start pulse, then waits for count_done. A
// watchdog limits every wait to TIMEOUT_CYCLES cycles; overrunning it raises
// a sticky error that only clear removes. abort cancels a job at any point
// between issue and finish.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   go           job request, only looked at while idle
//   abort        cancel the job in progress
//   clear        drop the sticky error and return to idle
//   count_done   done pulse from the attached counter
//   count_start  start pulse to the attached counter
//   busy         high while a job is in progress
//   finished     one-cycle pulse after a job completes normally
//   error        sticky watchdog-timeout flag
//   rounds_done  completed runs in the current or last job
// ---------------------------------------------------------------------------
module counter_sequencer #(
  parameter int                       ROUNDS         = 3,
  parameter int                       ROUND_WIDTH    = 4,
  parameter int                       TIMEOUT_WIDTH  = 10,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 10'd300
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   abort,
  input  logic                   clear,
  input  logic                   count_done,
  output logic                   count_start,
  output logic                   busy,
  output logic                   finished,
  output logic                   error,
  output logic [ROUND_WIDTH-1:0] rounds_done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    FINISH,
    ERROR
  } state_t;

  localparam logic [ROUND_WIDTH-1:0]   ROUNDS_L = ROUND_WIDTH'(ROUNDS);
  localparam logic [ROUND_WIDTH-1:0]   RD_ONE   = ROUND_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE   = TIMEOUT_WIDTH'(1);
  // Last watchdog value that still allows a run to complete.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST  = TIMEOUT_CYCLES - WD_ONE;

  state_t                   state, state_next;
  logic [TIMEOUT_WIDTH-1:0] watchdog, watchdog_next;
  logic                     count_start_next;
  logic                     busy_next;
  logic                     finished_next;
  logic                     error_next;
  logic [ROUND_WIDTH-1:0]   rounds_done_next;
  logic [ROUND_WIDTH-1:0]   rounds_inc;

  // State and all outputs are registered together so every output changes
  // exactly on the edge that moves the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      watchdog    <= '0;
      count_start <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      error       <= 1'b0;
      rounds_done <= '0;
    end else begin
      state       <= state_next;
      watchdog    <= watchdog_next;
      count_start <= count_start_next;
      busy        <= busy_next;
      finished    <= finished_next;
      error       <= error_next;
      rounds_done <= rounds_done_next;
    end
  end

  // Next-state and next-output logic. Everything holds unless a state says
  // otherwise. Within WAIT_DONE the priority is abort, then count_done, then
  // the watchdog, so a done arriving on the last allowed cycle still counts.
  always_comb begin
    state_next       = state;
    watchdog_next    = watchdog;
    count_start_next = count_start;
    busy_next        = busy;
    finished_next    = finished;
    error_next       = error;
    rounds_done_next = rounds_done;
    rounds_inc       = rounds_done + RD_ONE;

    case (state)
      IDLE: begin
        finished_next = 1'b0;
        if (go) begin
          rounds_done_next = '0;
          busy_next        = 1'b1;
          count_start_next = 1'b1;
          state_next       = ISSUE;
        end
      end

      ISSUE: begin
        count_start_next = 1'b0;
        if (abort) begin
          busy_next     = 1'b0;
          finished_next = 1'b0;
          state_next    = IDLE;
        end else begin
          watchdog_next = '0;
          state_next    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (abort) begin
          busy_next        = 1'b0;
          count_start_next = 1'b0;
          finished_next    = 1'b0;
          state_next       = IDLE;
        end else if (count_done) begin
          rounds_done_next = rounds_inc;
          if (rounds_inc == ROUNDS_L) begin
            state_next = FINISH;
          end else begin
            count_start_next = 1'b1;
            state_next       = ISSUE;
          end
        end else if (watchdog == WD_LAST) begin
          error_next = 1'b1;
          busy_next  = 1'b0;
          state_next = ERROR;
        end else begin
          watchdog_next = watchdog + WD_ONE;
        end
      end

      FINISH: begin
        busy_next        = 1'b0;
        count_start_next = 1'b0;
        state_next       = IDLE;
        finished_next    = ~abort;
      end

      ERROR: begin
        if (clear) begin
          error_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//
// Randomised bench for counter_sequencer. A job-level reference model
// (is a job live, is this an issue cycle, how long has the current run been
// waiting, how many runs are done) predicts every output each cycle. A
// counter responder answers each count_start after a chosen delay.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

  localparam int ROUNDS         = 3;
  localparam int ROUND_WIDTH    = 4;
  localparam int TIMEOUT_WIDTH  = 10;
  localparam int TIMEOUT_CYCLES = 300;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   go;
  logic                   abort;
  logic                   clear;
  logic                   count_done;
  logic                   count_start;
  logic                   busy;
  logic                   finished;
  logic                   error;
  logic [ROUND_WIDTH-1:0] rounds_done;

  counter_sequencer #(
    .ROUNDS        (ROUNDS),
    .ROUND_WIDTH   (ROUND_WIDTH),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(10'd300)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .abort      (abort),
    .clear      (clear),
    .count_done (count_done),
    .count_start(count_start),
    .busy       (busy),
    .finished   (finished),
    .error      (error),
    .rounds_done(rounds_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_job, m_issue, m_finishing, m_err, m_fin;
  int m_runs, m_age;

  // Stimulus configuration and responder.
  int          cfg_delay;
  int unsigned cfg_go_pct, cfg_abort_pct, cfg_clear_pct, cfg_stray_pct;
  bit          cfg_go_hold;
  int          resp_cnt;

  // Observation statistics.
  int cyc, start_seen, fin_seen, last_start_cyc, error_rise_cyc;
  bit last_error;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_job = 0; m_issue = 0; m_finishing = 0; m_err = 0; m_fin = 0;
    m_runs = 0; m_age = 0; resp_cnt = 0;
  endtask

  // One clock of the job-level model, using the inputs present at the edge.
  task automatic modelStep();
    bit fin_n;
    fin_n = 0;
    if (m_err) begin
      if (clear) m_err = 0;
    end else if (!m_job) begin
      if (go) begin
        m_job = 1; m_issue = 1; m_runs = 0;
      end
    end else if (abort) begin
      m_job = 0; m_issue = 0; m_finishing = 0;
    end else if (m_issue) begin
      m_issue = 0; m_age = 0;
    end else if (m_finishing) begin
      m_finishing = 0; m_job = 0; fin_n = 1;
    end else if (count_done) begin
      m_runs++;
      if (m_runs == ROUNDS) m_finishing = 1;
      else m_issue = 1;
    end else if (m_age + 1 == TIMEOUT_CYCLES) begin
      m_err = 1; m_job = 0;
    end else begin
      m_age++;
    end
    m_fin = fin_n;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".count_start"}, 32'(count_start), 32'(m_issue));
    checkOutput({tag, ".busy"},        32'(busy),        32'(m_job));
    checkOutput({tag, ".finished"},    32'(finished),    32'(m_fin));
    checkOutput({tag, ".error"},       32'(error),       32'(m_err));
    checkOutput({tag, ".rounds_done"}, 32'(rounds_done), 32'(m_runs));
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) modelStep();
    @(negedge clock);
    cyc++;
    checkAll("cyc");
    if (count_start) begin
      start_seen++;
      last_start_cyc = cyc;
    end
    if (finished) fin_seen++;
    if (error && !last_error) error_rise_cyc = cyc;
    last_error = error;
  endtask

  // Drives the inputs for the next edge. The responder arms in the issue
  // cycle and raises count_done in the cfg_delay-th wait cycle.
  task automatic applyStimulus();
    go    = cfg_go_hold || ($urandom_range(99) < cfg_go_pct);
    abort = $urandom_range(99) < cfg_abort_pct;
    clear = $urandom_range(99) < cfg_clear_pct;
    count_done = 1'b0;
    if (m_issue) begin
      if (cfg_delay == -2)
        resp_cnt = ($urandom_range(19) == 0) ? -1 : int'($urandom_range(15, 1));
      else
        resp_cnt = cfg_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) count_done = 1'b1;
    end
    if ($urandom_range(99) < cfg_stray_pct) count_done = 1'b1;
  endtask

  task automatic startJob(input int delay);
    cfg_delay  = delay;
    resp_cnt   = 0;
    start_seen = 0;
    fin_seen   = 0;
    applyStimulus();
    go = 1'b1;
    tick();
  endtask

  task automatic runUntilIdle(input int maxCycles);
    int n;
    n = 0;
    do begin
      applyStimulus();
      tick();
      n++;
    end while (m_job && n < maxCycles);
    if (m_job) checkOutput("bound.busy", 32'(busy), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      tick();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; go = 1'b0; abort = 1'b0; clear = 1'b0; count_done = 1'b0;
    cfg_delay = 10; cfg_go_pct = 0; cfg_abort_pct = 0; cfg_clear_pct = 0;
    cfg_stray_pct = 0; cfg_go_hold = 0;
    cyc = 0; start_seen = 0; fin_seen = 0; last_start_cyc = 0;
    error_rise_cyc = 0; last_error = 0;
    modelReset();

    repeat (2) @(negedge clock);
    checkAll("reset");
    reset = 1'b0;
    idleCycles(3);

    // Normal job, counter answers 10 cycles after each start.
    startJob(10);
    runUntilIdle(200);
    checkOutput("normal.starts",   32'(start_seen),  32'd3);
    checkOutput("normal.finished", 32'(fin_seen),    32'd1);
    checkOutput("normal.rounds",   32'(rounds_done), 32'd3);
    checkOutput("normal.busy",     32'(busy),        32'd0);
    idleCycles(3);

    // Timeout: the counter never answers. The ISSUE cycle is followed by
    // TIMEOUT_CYCLES wait cycles, and error shows in the cycle after those.
    startJob(-1);
    runUntilIdle(400);
    checkOutput("timeout.error", 32'(error), 32'd1);
    checkOutput("timeout.busy",  32'(busy),  32'd0);
    checkOutput("timeout.latency", 32'(error_rise_cyc - last_start_cyc),
                32'(TIMEOUT_CYCLES + 1));
    idleCycles(4);
    checkOutput("timeout.sticky", 32'(error), 32'd1);
    applyStimulus(); clear = 1'b1; tick();
    checkOutput("timeout.cleared", 32'(error), 32'd0);
    idleCycles(2);

    // Boundary: done in the last allowed wait cycle counts every run.
    startJob(TIMEOUT_CYCLES);
    runUntilIdle(1200);
    checkOutput("edge300.error",  32'(error),       32'd0);
    checkOutput("edge300.rounds", 32'(rounds_done), 32'd3);
    checkOutput("edge300.fin",    32'(fin_seen),    32'd1);
    idleCycles(2);

    // One cycle later is too late.
    startJob(TIMEOUT_CYCLES + 1);
    runUntilIdle(400);
    checkOutput("edge301.error",  32'(error),       32'd1);
    checkOutput("edge301.rounds", 32'(rounds_done), 32'd0);
    applyStimulus(); clear = 1'b1; tick();
    idleCycles(2);

    // Abort during the second wait.
    startJob(10);
    n = 0;
    while (!(m_job && !m_issue && m_runs == 1 && m_age == 4) && n < 100) begin
      applyStimulus();
      tick();
      n++;
    end
    applyStimulus(); abort = 1'b1; tick();
    checkOutput("abort.busy",   32'(busy),        32'd0);
    checkOutput("abort.rounds", 32'(rounds_done), 32'd1);
    idleCycles(15);
    checkOutput("abort.nofin",  32'(fin_seen),    32'd0);
    startJob(10);
    checkOutput("restart.rounds", 32'(rounds_done), 32'd0);
    runUntilIdle(200);
    checkOutput("restart.fin", 32'(fin_seen), 32'd1);

    // go held through whole jobs; new jobs only start from idle.
    cfg_delay = 5; cfg_go_hold = 1; start_seen = 0;
    idleCycles(100);
    cfg_go_hold = 0;
    runUntilIdle(100);
    idleCycles(2);
    start_seen = 0;
    cfg_stray_pct = 50;
    idleCycles(20);
    checkOutput("idle.stray.starts", 32'(start_seen), 32'd0);
    cfg_stray_pct = 0;

    // Asynchronous reset between edges while waiting.
    startJob(10);
    n = 0;
    while (!(m_job && !m_issue && m_age == 4) && n < 50) begin
      applyStimulus();
      tick();
      n++;
    end
    #2 reset = 1'b1;
    modelReset();
    #1 checkAll("areset");
    checkOutput("areset.busy", 32'(busy), 32'd0);
    go = 1'b0; abort = 1'b0; clear = 1'b0; count_done = 1'b0;
    tick();
    #2 reset = 1'b0;
    fin_seen = 0;
    idleCycles(5);
    checkOutput("areset.nofin", 32'(fin_seen), 32'd0);
    startJob(10);
    runUntilIdle(200);
    checkOutput("areset.job.fin",    32'(fin_seen),   32'd1);
    checkOutput("areset.job.starts", 32'(start_seen), 32'd3);

    // Random soak.
    cfg_delay = -2; cfg_go_pct = 20; cfg_abort_pct = 2;
    cfg_clear_pct = 10; cfg_stray_pct = 5;
    idleCycles(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
